// File: rtl/check_test_stream_if.sv
// Status/stream bundle between one incoming test line and its checker.
// Master side drives Start, Stream and Address; slave side (the checker) returns the result fields.
// FirstErr is present only when CHK_FIRSTERR_EN is defined.
interface check_test_stream_if #(
    parameter int WIDTH   = 24,
    parameter int ERRBITS = 16
);
    logic               Start;
    logic               Stream;
    logic [3:0]         Address;
    logic               Busy;
    logic               Done;
    logic               Pass;
    logic               NoStart;
    logic [ERRBITS-1:0] ErrCnt;
    logic [WIDTH-1:0]   WordCnt;
`ifdef CHK_FIRSTERR_EN
    logic [WIDTH-1:0]   FirstErr;
`endif

    // Address rides on the bus so status consumers can tell lines apart.
    modport master (
        output Start, Stream, Address,
        input  Busy, Done, Pass, NoStart, ErrCnt, WordCnt
`ifdef CHK_FIRSTERR_EN
        , input FirstErr
`endif
    );

    modport slave (
        input  Start, Stream, Address,
        output Busy, Done, Pass, NoStart, ErrCnt, WordCnt
`ifdef CHK_FIRSTERR_EN
        , output FirstErr
`endif
    );
endinterface

// File: rtl/check_test_stream.sv
// Purpose: deserializes the test stream on one line (MSB first, back-to-back WIDTH-bit words)
//          and checks it against the down-counting sequence 2^WIDTH-1 .. 1.
// Latency: pin-to-S is 2 cycles; Done pulses 1 cycle after the last bit of word 1 sits in S.
// Backpressure: none; the line is sampled every cycle, Start outside Idle is ignored.
// Ports: Clock, Reset (async active-low), bus (slave modport: Start/Stream/Address in,
//        Busy/Done/Pass/NoStart/ErrCnt/WordCnt out, FirstErr out with CHK_FIRSTERR_EN).
// Optional feature: define CHK_FIRSTERR_EN to capture the first mismatching word in FirstErr.
module check_test_stream #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 1024,
    parameter int ERRBITS = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    check_test_stream_if.slave bus
);
    localparam int BW = (WIDTH   > 2) ? $clog2(WIDTH)   : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, HUNT, RCV, FIN} state_t;

    state_t             state;
    logic               sync_q1;
    logic               s_q;
    logic [WIDTH-1:0]   expected;
    logic [WIDTH-1:0]   shift;
    logic [BW-1:0]      bit_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               nostart_q;
    logic [ERRBITS-1:0] err_cnt;
    logic [WIDTH-1:0]   word_cnt;
`ifdef CHK_FIRSTERR_EN
    logic [WIDTH-1:0]   first_err_q;
    logic               err_seen;
`endif

    // Word as it stands once the current S bit is appended.
    logic [WIDTH-1:0]   rx;
    logic               mismatch;
    logic [ERRBITS-1:0] err_nxt;

    always_comb begin
        rx       = {shift[WIDTH-2:0], s_q};
        mismatch = (rx != expected);
        err_nxt  = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_nxt = err_cnt + ERRBITS'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            sync_q1     <= 1'b0;
            s_q         <= 1'b0;
            expected    <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            nostart_q   <= 1'b0;
            err_cnt     <= '0;
            word_cnt    <= '0;
`ifdef CHK_FIRSTERR_EN
            first_err_q <= '0;
            err_seen    <= 1'b0;
`endif
        end else begin
            sync_q1 <= bus.Stream;
            s_q     <= sync_q1;
            done_q  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        expected  <= '1;
                        err_cnt   <= '0;
                        word_cnt  <= '0;
                        nostart_q <= 1'b0;
                        pass_q    <= 1'b0;
                        tmo_cnt   <= '0;
                        busy_q    <= 1'b1;
`ifdef CHK_FIRSTERR_EN
                        first_err_q <= '0;
                        err_seen    <= 1'b0;
`endif
                        state     <= HUNT;
                    end
                end

                HUNT: begin
                    // The lock bit is the MSB of word 0 and is always 1.
                    if (s_q) begin
                        shift   <= WIDTH'(1);
                        bit_cnt <= BW'(1);
                        state   <= RCV;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        nostart_q <= 1'b1;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                RCV: begin
                    shift <= rx;
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        word_cnt <= word_cnt + WIDTH'(1);
                        err_cnt  <= err_nxt;
`ifdef CHK_FIRSTERR_EN
                        if (mismatch && !err_seen) begin
                            first_err_q <= rx;
                            err_seen    <= 1'b1;
                        end
`endif
                        bit_cnt <= '0;
                        if (expected == WIDTH'(1)) begin
                            // err_nxt is zero only if no word of this test mismatched.
                            pass_q <= (err_nxt == '0);
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= FIN;
                        end else begin
                            expected <= expected - WIDTH'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Pass     = pass_q;
    assign bus.NoStart  = nostart_q;
    assign bus.ErrCnt   = err_cnt;
    assign bus.WordCnt  = word_cnt;
`ifdef CHK_FIRSTERR_EN
    assign bus.FirstErr = first_err_q;
`endif
endmodule

// File: tb/tb_check_test_stream.sv
// Bench for check_test_stream with WIDTH=4, TIMEOUT=16, ERRBITS=3.
// Each test builds a bit stream, a word-level model predicts the result and pushes it to a
// scoreboard; a monitor pops and compares whenever Done pulses.
module tb_check_test_stream;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int ERRBITS = 3;
    localparam int NWORDS  = (1 << WIDTH) - 1;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    check_test_stream_if #(.WIDTH(WIDTH), .ERRBITS(ERRBITS)) bus ();

    check_test_stream #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT),
        .ERRBITS(ERRBITS)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic               pass;
        logic               nostart;
        logic [ERRBITS-1:0] err;
        logic [WIDTH-1:0]   words;
        logic [WIDTH-1:0]   first;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   stim[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Word-level reference: find the lock bit, cut NWORDS words, compare to the count-down.
    function automatic exp_t model_stream();
        exp_t             r;
        int               idx;
        logic [WIDTH-1:0] exp_w;
        logic [WIDTH-1:0] rx;
        bit               seen;
        bit               b_v;
        r     = '0;
        seen  = 1'b0;
        idx   = 0;
        while (idx < stim.size() && stim[idx] == 1'b0) idx++;
        if (idx >= stim.size()) begin
            r.nostart = 1'b1;
            return r;
        end
        exp_w = '1;
        for (int w = 0; w < NWORDS; w++) begin
            rx = '0;
            for (int b = 0; b < WIDTH; b++) begin
                b_v = (idx < stim.size()) ? stim[idx] : 1'b0;
                rx  = {rx[WIDTH-2:0], b_v};
                idx++;
            end
            r.words = r.words + 1'b1;
            if (rx != exp_w) begin
                if (r.err != '1) r.err = r.err + 1'b1;
                if (!seen) begin
                    r.first = rx;
                    seen    = 1'b1;
                end
            end
            exp_w = exp_w - 1'b1;
        end
        r.pass = (r.err == '0);
        return r;
    endfunction

    // mode 0 clean, 1 word 7 replaced by arg, 2 delete bit index arg,
    // 3 lock bit then zeros, 4 lock bit then random bits
    task automatic build(input int mode, input int arg);
        logic [WIDTH-1:0] w;
        stim.delete();
        if (mode == 3 || mode == 4) begin
            stim.push_back(1'b1);
            for (int i = 1; i < NWORDS * WIDTH; i++)
                stim.push_back((mode == 4) ? bit'($urandom_range(1, 0)) : 1'b0);
        end else begin
            for (int v = NWORDS; v >= 1; v--) begin
                w = WIDTH'(v);
                if (mode == 1 && v == 7) w = WIDTH'(arg);
                for (int b = WIDTH - 1; b >= 0; b--) stim.push_back(w[b]);
            end
            if (mode == 2) stim.delete(arg);
        end
    endtask

    // Start at position 0, stream from position delay; optional ignored Start inside the stream.
    task automatic run(input string tag, input int delay, input int stray, input int exp_lat);
        exp_t e;
        int   base;
        int   waited;
        int   len;
        e    = model_stream();
        sb.push_back(e);
        base = done_cnt;
        len  = delay + stim.size();
        if (len < 1) len = 1;
        for (int i = 0; i < len; i++) begin
            bus.Start  = (i == 0) || (stray >= 0 && i == delay + stray);
            bus.Stream = (i >= delay && (i - delay) < stim.size()) ? stim[i - delay] : 1'b0;
            tick();
            if (i == 0) chk({tag, "_busy"}, bus.Busy, 1);
        end
        bus.Start  = 1'b0;
        bus.Stream = 1'b0;
        waited = 0;
        while (!bus.Done && waited < 40) begin
            tick();
            waited++;
        end
        chk({tag, "_done_lat"}, waited, exp_lat);
        repeat (4) tick();
        chk({tag, "_done_once"}, done_cnt - base, 1);
        chk({tag, "_pass_hold"}, bus.Pass, e.pass);
        if (done_cnt == base) sb.delete();
    endtask

    always @(posedge Clock) begin
        #1;
        if (bus.Done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_pass",    bus.Pass,    mon_e.pass);
                chk("done_nostart", bus.NoStart, mon_e.nostart);
                chk("done_errcnt",  bus.ErrCnt,  mon_e.err);
                chk("done_wordcnt", bus.WordCnt, mon_e.words);
                chk("done_busy",    bus.Busy,    0);
`ifdef CHK_FIRSTERR_EN
                chk("done_firsterr", bus.FirstErr, mon_e.first);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    bus.Busy,    0);
        chk({tag, "_done"},    bus.Done,    0);
        chk({tag, "_pass"},    bus.Pass,    0);
        chk({tag, "_nostart"}, bus.NoStart, 0);
        chk({tag, "_errcnt"},  bus.ErrCnt,  0);
        chk({tag, "_wordcnt"}, bus.WordCnt, 0);
`ifdef CHK_FIRSTERR_EN
        chk({tag, "_firsterr"}, bus.FirstErr, 0);
`endif
    endtask

    initial begin
        int base;
        bus.Start   = 1'b0;
        bus.Stream  = 1'b0;
        bus.Address = 4'd5;
        #2 Reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        Reset = 1'b1;
        tick();
        $display("checking line %0d", bus.Address);

        build(0, 0);  run("clean", 3, -1, 2);
        build(1, 5);  run("word7", 3, 30, 2);
        build(2, 13); run("slip", 3, -1, 3);
        chk("slip_err_sat", bus.ErrCnt, 7);
        stim.delete(); run("timeout", 1, -1, 16);
        build(3, 0);  run("zeros", 0, -1, 2);

        // Reset in the middle of word 9: six words already received.
        build(0, 0);
        base = done_cnt;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 26; i++) begin
            bus.Stream = stim[i];
            tick();
        end
        chk("pre_rst_words", bus.WordCnt, 6);
        chk("pre_rst_busy",  bus.Busy,    1);
        #2 Reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.Stream = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        repeat (30) tick();
        chk("midrst_no_done", done_cnt - base, 0);
        chk("midrst_idle",    bus.Busy,        0);

        build(0, 0); run("after_rst", 2, -1, 2);
        build(4, 0); run("rand1", 2, -1, 2);
        build(4, 0); run("rand2", 1, -1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/check_test_stream.md
# check_test_stream

Receiving-end checker for the serial test stream that front-end boards send to the event builder to exercise the data transmission lines. The block samples one serial line, locks onto the leading edge of the first test word, and deserializes back-to-back WIDTH-bit words, MSB first, with no gaps or framing. Each word is compared against the expected down-counting sequence, from all-ones down to 1. At the end, the block reports word count, error count and a pass flag, then pulses Done. One instance sits per incoming line in the event builder.

## Interface
- WIDTH, 24: word width in bits; the expected sequence is 2^WIDTH-1 down to 1 inclusive.
- TIMEOUT, 1024: cycles to wait for the first stream bit after Start before aborting.
- ERRBITS, 16: width of the error counter.
- Clock  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that arms the checker.
- Stream  input  1  serial test line; low when idle.
- Address  input  4  line/board number, carried to the status bus only.
- Busy  output  1  high from the cycle after Start until the cycle Done pulses.
- Done  output  1  one-cycle pulse at the end of a test.
- Pass  output  1  valid from Done until the next Start.
- NoStart  output  1  set when the test aborted on timeout.
- ErrCnt  output  ERRBITS  count of mismatched words; saturates at all-ones.
- WordCnt  output  WIDTH  number of words received.
- FirstErr  output  WIDTH  first mismatching word received. Present only with CHK_FIRSTERR_EN.

## Operation
- Input path: Stream passes through a 2-flop synchronizer. All references to "bit" below mean the synchronized value, S.
- Idle:
  - Start loads Expected=2^WIDTH-1 and clears ErrCnt, WordCnt, NoStart, Pass and TmoCnt, then moves to Hunt.
  - A Start received in any other state is ignored.
- Hunt:
  - The first S=1 is bit WIDTH-1 of word 0. Load Shift={..,1}, set BitCnt=1, move to Rcv.
  - While waiting, TmoCnt increments each cycle. At TmoCnt==TIMEOUT-1, set NoStart=1, Pass=0, move to Fin.
- Rcv, each cycle:
  - Shift <= {Shift[WIDTH-2:0],S} and BitCnt increments.
  - When BitCnt==WIDTH-1, the word completes in the same cycle as Rx={Shift[WIDTH-2:0],S}:
    - WordCnt increments.
    - If Rx!=Expected, ErrCnt increments (saturating).
    - If Expected==1, move to Fin. Otherwise Expected decrements, BitCnt returns to 0, and reception continues with no idle cycle.
- Fin: Done=1 for one cycle, Pass=(ErrCnt==0 && !NoStart), Busy drops, return to Idle.
- Arithmetic rules:
  - Expected is WIDTH bits and never wraps, because the test terminates at 1.
  - WordCnt at a clean finish equals 2^WIDTH-1.
- A dropped or extra bit slips alignment; every following word then mismatches. That is the required, diagnosable behaviour. There is no resynchronization.
- The lock bit is fixed at 1 by construction, so a stuck-high line passes only word 0.

## Timing
- Reset values: Busy=0, Done=0, Pass=0, NoStart=0, ErrCnt=0, WordCnt=0, FirstErr=0. State is Idle, synchronizer flops are 0.
- Reset asserted mid-test aborts immediately, with no Done. After release the block waits in Idle.
- Latency: the stream bit at the pin reaches S 2 cycles later. Done pulses 1 cycle after the cycle in which the last bit of word 1 sits in S.
- Start and the first stream bit may arrive in the same cycle. That bit is still in the synchronizer, so it is not lost.
- A transmitter Done-to-Start round trip needs no handshake. Start here must precede the transmitter's Start by at least 0 cycles and by at most TIMEOUT-3 cycles.

## Configuration
- CHK_FIRSTERR_EN defined: the FirstErr port and register exist. FirstErr captures Rx at the first mismatch of a test and holds it until the next Start.
- Macro undefined: no FirstErr port and no capture logic. All other behaviour is identical.

## Test plan
- WIDTH=4. Start, then 3 cycles later send F,E,…,1 serially (60 bits) -> Done pulses once, Pass=1, ErrCnt=0, WordCnt=15, NoStart=0.
- WIDTH=4, same stream with word 7 sent as 5 -> Pass=0, ErrCnt=1, WordCnt=15. With the macro, FirstErr=5.
- WIDTH=4, one bit deleted inside word C -> ErrCnt≥10, WordCnt=15 after 4 extra padding bits. Pass=0.
- TIMEOUT=16. Start with Stream held low -> Done exactly 16 cycles after Hunt entry, NoStart=1, Pass=0, WordCnt=0.
- Reset pulsed low while in word 9 -> all outputs return to 0 asynchronously, no Done. A new Start plus a clean stream then passes.
- ERRBITS=2, WIDTH=4, stream of all zeros after the lock bit -> ErrCnt saturates at 3, Pass=0.
